// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - fetch/decode/execute control-step sequencer for one single-bus ALU instruction.
// Optional ALU_SEQ_R0_GUARD_EN: when defined, R0 is never written (reg_in_o[0] held low).
module alu_op_sequencer #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OPCODE_W  = 5
) (
  input  logic                clk_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   ir_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                illegal_o,
  output logic                pc_out_o,
  output logic                mar_in_o,
  output logic                inc_pc_o,
  output logic                z_in_o,
  output logic                z_low_out_o,
  output logic                z_high_out_o,
  output logic                pc_in_o,
  output logic                read_o,
  output logic                mdr_in_o,
  output logic                mdr_out_o,
  output logic                ir_in_o,
  output logic                y_in_o,
  output logic                hi_in_o,
  output logic                lo_in_o,
  output logic [NUM_REGS-1:0] reg_in_o,
  output logic [NUM_REGS-1:0] reg_out_o,
  output logic [12:0]         alu_op_o
);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
  typedef enum logic [1:0] {C_BIN, C_UN, C_MD, C_ILL} cls_t;

  state_t                 state_q, state_d;
  cls_t                   cls_q, dec_cls;
  logic [OPCODE_W-1:0]    op_q, dec_op;
  logic [REG_IDX_W-1:0]   ra_q, rb_q, rc_q, dec_ra, dec_rb, dec_rc;
  logic                   done_q, done_d, illegal_q, illegal_d;
  logic [NUM_REGS-1:0]    reg_in_raw;

  assign dec_op = ir_i[DATA_W-1 -: OPCODE_W];
  assign dec_ra = ir_i[DATA_W-OPCODE_W-1 -: REG_IDX_W];
  assign dec_rb = ir_i[DATA_W-OPCODE_W-REG_IDX_W-1 -: REG_IDX_W];
  assign dec_rc = ir_i[DATA_W-OPCODE_W-2*REG_IDX_W-1 -: REG_IDX_W];

  function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  function automatic logic [12:0] alu_onehot(input logic [OPCODE_W-1:0] op);
    logic [12:0] r;
    r = '0;
    case (int'(op))
      3:  r[0]  = 1'b1;
      4:  r[1]  = 1'b1;
      5:  r[7]  = 1'b1;
      6:  r[8]  = 1'b1;
      7:  r[5]  = 1'b1;
      8:  r[6]  = 1'b1;
      9:  r[2]  = 1'b1;
      10: r[3]  = 1'b1;
      11: r[4]  = 1'b1;
      15: r[9]  = 1'b1;
      16: r[10] = 1'b1;
      17: r[11] = 1'b1;
      18: r[12] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Out-of-range register fields demote an otherwise valid opcode to illegal.
  always_comb begin
    dec_cls = C_ILL;
    case (int'(dec_op))
      3, 4, 5, 6, 7, 8, 9, 10, 11:
        if (idx_ok(dec_ra) && idx_ok(dec_rb) && idx_ok(dec_rc)) dec_cls = C_BIN;
      15, 16:
        if (idx_ok(dec_ra) && idx_ok(dec_rb)) dec_cls = C_MD;
      17, 18:
        if (idx_ok(dec_ra) && idx_ok(dec_rb)) dec_cls = C_UN;
      default: dec_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cls_q     <= C_ILL;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (state_q == S_T3) begin
        cls_q <= dec_cls;
        op_q  <= dec_op;
        ra_q  <= dec_ra;
        rb_q  <= dec_rb;
        rc_q  <= dec_rc;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:
        if (dec_cls == C_ILL) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = S_T4;
        end
      S_T4:
        if (cls_q == C_UN) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_T5;
        end
      S_T5:
        if (cls_q == C_MD) begin
          state_d = S_T6;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      S_T6: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // T3 decodes straight from ir_i; later steps only see the captured copy.
  always_comb begin
    pc_out_o     = 1'b0;
    mar_in_o     = 1'b0;
    inc_pc_o     = 1'b0;
    z_in_o       = 1'b0;
    z_low_out_o  = 1'b0;
    z_high_out_o = 1'b0;
    pc_in_o      = 1'b0;
    read_o       = 1'b0;
    mdr_in_o     = 1'b0;
    mdr_out_o    = 1'b0;
    ir_in_o      = 1'b0;
    y_in_o       = 1'b0;
    hi_in_o      = 1'b0;
    lo_in_o      = 1'b0;
    reg_in_raw   = '0;
    reg_out_o    = '0;
    alu_op_o     = '0;
    case (state_q)
      S_T0: begin
        pc_out_o = 1'b1;
        mar_in_o = 1'b1;
        inc_pc_o = 1'b1;
        z_in_o   = 1'b1;
      end
      S_T1: begin
        z_low_out_o = 1'b1;
        pc_in_o     = 1'b1;
        read_o      = 1'b1;
        mdr_in_o    = 1'b1;
      end
      S_T2: begin
        mdr_out_o = 1'b1;
        ir_in_o   = 1'b1;
      end
      S_T3:
        case (dec_cls)
          C_BIN: begin
            reg_out_o = onehot(dec_rb);
            y_in_o    = 1'b1;
          end
          C_UN: begin
            reg_out_o = onehot(dec_rb);
            alu_op_o  = alu_onehot(dec_op);
            z_in_o    = 1'b1;
          end
          C_MD: begin
            reg_out_o = onehot(dec_ra);
            y_in_o    = 1'b1;
          end
          default: ;
        endcase
      S_T4:
        case (cls_q)
          C_BIN: begin
            reg_out_o = onehot(rc_q);
            alu_op_o  = alu_onehot(op_q);
            z_in_o    = 1'b1;
          end
          C_UN: begin
            z_low_out_o = 1'b1;
            reg_in_raw  = onehot(ra_q);
          end
          C_MD: begin
            reg_out_o = onehot(rb_q);
            alu_op_o  = alu_onehot(op_q);
            z_in_o    = 1'b1;
          end
          default: ;
        endcase
      S_T5: begin
        z_low_out_o = 1'b1;
        if (cls_q == C_MD) lo_in_o = 1'b1;
        else reg_in_raw = onehot(ra_q);
      end
      S_T6: begin
        z_high_out_o = 1'b1;
        hi_in_o      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    reg_in_o = reg_in_raw;
`ifdef ALU_SEQ_R0_GUARD_EN
    reg_in_o[0] = 1'b0;
`else
    reg_in_o[0] = reg_in_raw[0];
`endif
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - cycle-by-cycle vector table bench for alu_op_sequencer.
module tb_alu_op_sequencer;

  localparam logic [13:0] PCOUT = 14'h2000, MARIN = 14'h1000, INCPC = 14'h0800, ZIN = 14'h0400,
                          ZLO = 14'h0200, ZHI = 14'h0100, PCIN = 14'h0080, READ = 14'h0040,
                          MDRIN = 14'h0020, MDROUT = 14'h0010, IRIN = 14'h0008, YIN = 14'h0004,
                          HIIN = 14'h0002, LOIN = 14'h0001;
  localparam logic [13:0] T0E = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [13:0] T1E = ZLO | PCIN | READ | MDRIN;
  localparam logic [13:0] T2E = MDROUT | IRIN;
`ifdef ALU_SEQ_R0_GUARD_EN
  localparam logic [15:0] R0_WR = 16'h0000;
`else
  localparam logic [15:0] R0_WR = 16'h0001;
`endif

  localparam logic [31:0] I_AND  = 32'h28918000;
  localparam logic [31:0] I_NEG  = 32'h8B380000;
  localparam logic [31:0] I_MUL  = 32'h79180000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;
  localparam logic [31:0] I_GAP  = 32'h60000000;
  localparam logic [31:0] I_ADD0 = 32'h18090000;
  localparam logic [31:0] I_ADD  = 32'h1A2B0000;

  typedef struct packed {
    logic        busy, done, ill;
    logic [13:0] strb;
    logic [15:0] rin, rout;
    logic [12:0] alu;
  } out_t;

  typedef struct {
    logic        clr, st;
    logic [31:0] ir;
    out_t        exp;
  } vec_t;

  logic        clk, clear, start;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic        pc_out, mar_in, inc_pc, z_in, z_low_out, z_high_out, pc_in, read, mdr_in, mdr_out;
  logic        ir_in, y_in, hi_in, lo_in;
  logic [15:0] reg_in, reg_out;
  logic [12:0] alu_op;
  out_t        got;
  vec_t        vq[$];
  int          checks = 0;
  int          fails = 0;
  int          cycles;

  alu_op_sequencer dut (
    .clk_i(clk), .clear_i(clear), .start_i(start), .ir_i(ir),
    .busy_o(busy), .done_o(done), .illegal_o(illegal),
    .pc_out_o(pc_out), .mar_in_o(mar_in), .inc_pc_o(inc_pc), .z_in_o(z_in),
    .z_low_out_o(z_low_out), .z_high_out_o(z_high_out), .pc_in_o(pc_in), .read_o(read),
    .mdr_in_o(mdr_in), .mdr_out_o(mdr_out), .ir_in_o(ir_in), .y_in_o(y_in),
    .hi_in_o(hi_in), .lo_in_o(lo_in), .reg_in_o(reg_in), .reg_out_o(reg_out), .alu_op_o(alu_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = '{busy, done, illegal,
                 {pc_out, mar_in, inc_pc, z_in, z_low_out, z_high_out, pc_in, read,
                  mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in},
                 reg_in, reg_out, alu_op};

  task automatic row(input logic clr, input logic st, input logic [31:0] i,
                     input logic b, input logic d, input logic il, input logic [13:0] s,
                     input logic [15:0] ri, input logic [15:0] ro, input logic [12:0] a);
    vec_t v;
    v.clr = clr;
    v.st  = st;
    v.ir  = i;
    v.exp = '{b, d, il, s, ri, ro, a};
    vq.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] i, input logic st);
    row(1'b0, st, i, 1'b1, 1'b0, 1'b0, T0E, 16'h0, 16'h0, 13'h0);
    row(1'b0, st, i, 1'b1, 1'b0, 1'b0, T1E, 16'h0, 16'h0, 13'h0);
    row(1'b0, st, i, 1'b1, 1'b0, 1'b0, T2E, 16'h0, 16'h0, 13'h0);
  endtask

  task automatic idle(input logic st, input logic [31:0] i, input logic d, input logic il);
    row(1'b0, st, i, 1'b0, d, il, 14'h0, 16'h0, 16'h0, 13'h0);
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    ir    = 32'h0;

    idle(0, 32'h0, 0, 0);
    idle(1, I_AND, 0, 0);
    fetch(I_AND, 0);
    row(0, 0, I_AND, 1, 0, 0, YIN, 16'h0, 16'h0004, 13'h0);
    row(0, 0, 32'h0, 1, 0, 0, ZIN, 16'h0, 16'h0008, 13'h080);
    row(0, 0, 32'h0, 1, 0, 0, ZLO, 16'h0002, 16'h0, 13'h0);
    idle(0, 32'h0, 1, 0);
    idle(0, 32'h0, 0, 0);
    idle(1, I_NEG, 0, 0);
    fetch(I_NEG, 1);
    row(0, 0, I_NEG, 1, 0, 0, ZIN, 16'h0, 16'h0080, 13'h800);
    row(0, 0, I_NEG, 1, 0, 0, ZLO, 16'h0040, 16'h0, 13'h0);
    idle(0, I_NEG, 1, 0);
    idle(0, I_NEG, 0, 0);
    idle(1, I_MUL, 0, 0);
    fetch(I_MUL, 0);
    row(0, 0, I_MUL, 1, 0, 0, YIN, 16'h0, 16'h0004, 13'h0);
    row(0, 0, I_MUL, 1, 0, 0, ZIN, 16'h0, 16'h0008, 13'h200);
    row(0, 0, I_MUL, 1, 0, 0, ZLO | LOIN, 16'h0, 16'h0, 13'h0);
    row(0, 0, I_MUL, 1, 0, 0, ZHI | HIIN, 16'h0, 16'h0, 13'h0);
    idle(0, I_MUL, 1, 0);
    idle(1, I_BAD, 0, 0);
    fetch(I_BAD, 0);
    row(0, 0, I_BAD, 1, 0, 0, 14'h0, 16'h0, 16'h0, 13'h0);
    idle(0, I_BAD, 1, 1);
    idle(1, I_GAP, 0, 0);
    fetch(I_GAP, 0);
    row(0, 0, I_GAP, 1, 0, 0, 14'h0, 16'h0, 16'h0, 13'h0);
    idle(0, I_GAP, 1, 1);
    idle(0, I_GAP, 0, 0);
    idle(1, I_ADD0, 0, 0);
    fetch(I_ADD0, 0);
    row(0, 0, I_ADD0, 1, 0, 0, YIN, 16'h0, 16'h0002, 13'h0);
    row(0, 0, I_ADD0, 1, 0, 0, ZIN, 16'h0, 16'h0004, 13'h001);
    row(0, 0, I_ADD0, 1, 0, 0, ZLO, R0_WR, 16'h0, 13'h0);
    idle(0, I_ADD0, 1, 0);
    idle(1, I_ADD, 0, 0);
    fetch(I_ADD, 1);
    row(0, 1, I_ADD, 1, 0, 0, YIN, 16'h0, 16'h0020, 13'h0);
    row(0, 1, I_ADD, 1, 0, 0, ZIN, 16'h0, 16'h0040, 13'h001);
    row(0, 1, I_ADD, 1, 0, 0, ZLO, 16'h0010, 16'h0, 13'h0);
    idle(1, I_ADD, 1, 0);
    fetch(I_ADD, 0);
    row(0, 0, I_ADD, 1, 0, 0, YIN, 16'h0, 16'h0020, 13'h0);
    row(1, 0, I_ADD, 1, 0, 0, ZIN, 16'h0, 16'h0040, 13'h001);
    idle(0, I_ADD, 0, 0);
    idle(0, I_ADD, 0, 0);
    idle(0, I_ADD, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got !== '0) begin
        fails++;
        $display("FAIL reset: outputs not all zero after Clear, got %h", got);
    end
    foreach (vq[i]) begin
      #1;
      clear = vq[i].clr;
      start = vq[i].st;
      ir    = vq[i].ir;
      #1;
      checks++;
      if (got !== vq[i].exp) begin
        fails++;
        $display("FAIL row %0d: got busy/done/ill=%b%b%b strb=%h rin=%h rout=%h alu=%h, expected %b%b%b strb=%h rin=%h rout=%h alu=%h",
                 i, got.busy, got.done, got.ill, got.strb, got.rin, got.rout, got.alu,
                 vq[i].exp.busy, vq[i].exp.done, vq[i].exp.ill, vq[i].exp.strb,
                 vq[i].exp.rin, vq[i].exp.rout, vq[i].exp.alu);
      end
      @(posedge clk);
    end

    #1;
    clear = 1'b0;
    start = 1'b1;
    ir    = I_AND;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++;
    if (done !== 1'b1 || cycles != 7) begin
        fails++;
        $display("FAIL wait: done not seen 7 cycles after start (done=%b after %0d cycles)", done, cycles);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
